alu_driver: RTL and testbench
=============================

# alu_driver

Sequential initiator for the combinational 4-bit ALU (8 ops: add, sub, not, and, or, xor, compare, equal). It accepts packed operation commands on a valid/ready stream, drives the ALU operand and control inputs, and waits a programmable settle time. It then captures result, carry and overflow and returns them on a buffered valid/ready response stream. It sits between a command source (UART/keypad front end or testbench) and the ALU instance.

## Interface
- SETTLE_CYCLES, 1: cycles operands are held stable before capture; legal 1..15.
- FIFO_DEPTH, 4: response FIFO entries; power of two, 2..16.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at rising edge.
- cmd_data  in  11  {ctrl[10:8], a[7:4], b[3:0]}.
- alu_a, alu_b  out  4  operands to ALU.
- alu_ctrl  out  3  opcode to ALU.
- alu_res  in  4  ALU result.
- alu_car, alu_of  in  1  ALU carry / overflow.
- rsp_valid  out  1  response present (FIFO non-empty).
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_data  out  6  {of, car, res[3:0]} of FIFO head.
- op_count  out  8  completed operations, wraps 255→0.

## Operation
- FSM states: IDLE, DRIVE.
- IDLE: cmd_ready = (fifo_count + pending < FIFO_DEPTH). pending is 0 in IDLE, so cmd_ready = fifo not full. On accept: register alu_a/alu_b/alu_ctrl from cmd_data, load settle counter with SETTLE_CYCLES, go to DRIVE.
- DRIVE: cmd_ready = 0. The counter decrements each cycle. In the cycle where the counter equals 1, the rising edge pushes {alu_of, alu_car, alu_res} into the FIFO, increments op_count, and returns the FSM to IDLE.
- alu_a/alu_b/alu_ctrl hold their last values in IDLE; they never change while in DRIVE.
- Response FIFO is show-ahead: rsp_data is valid whenever rsp_valid=1. A push and a pop in the same cycle are both performed, and the count is unchanged.
- Full: no command is accepted, so a push can never overflow. Empty: rsp_valid=0, rsp_data holds its last value. A pop while empty is ignored.
- Reset (asynchronous, any state including mid-DRIVE): FSM→IDLE, FIFO emptied, op_count=0, alu_a=alu_b=0, alu_ctrl=3'b000. The in-flight operation is discarded, with no response.

## Timing
- Accept at edge E0 → alu_* new values visible after E0.
- Capture at edge E0+SETTLE_CYCLES. rsp_valid=1 in the following cycle if the FIFO was empty.
- Accept-to-response latency: SETTLE_CYCLES+1 edges.
- cmd_ready is reasserted in the cycle after capture. Maximum throughput is one op per SETTLE_CYCLES+1 cycles.
- All outputs are registered except cmd_ready, which is decoded from state and FIFO count.

## Configuration
- ALU_DRIVER_CHECK_EN defined: adds golden-model checker outputs mismatch (1 bit, sticky until reset) and err_count (8 bits, saturating at 255). At capture, {alu_of, alu_car, alu_res} is compared with the model computed from the latched operands. Model rules:
  - add: {car,res}=a+b (5 bit).
  - sub: t=(~b+1) truncated to 4 bits, then {car,res}=a+t.
  - of for add/sub: (a[3]==b[3]) && (res[3]!=a[3]).
  - not: ~a.
  - and / or / xor: bitwise.
  - compare: res=0 if a[3]=0&&b[3]=1; res=1 if a[3]=1&&b[3]=0; else res=(a<b)?0:1.
  - equal: res=(a==b)?0:1.
  - car=of=0 for all non-arithmetic ops.
  - A mismatch does not stall the response; the captured ALU value is still returned.
- Undefined: no checker logic, mismatch/err_count ports absent.

## Test plan
- Reset, SETTLE_CYCLES=1, add a=7,b=1 → rsp_data={of=1,car=0,res=8} two edges after accept; op_count=1.
- sub a=5,b=3 → res=2, car=1, of=0; compare a=2,b=9 → res=0, car=0, of=0; equal a=b=6 → res=0.
- rsp_ready=0, FIFO_DEPTH=4, five back-to-back commands → four accepted, cmd_ready=0 with fifth held; one pop → fifth accepted, responses returned in order.
- Assert rst_n low during DRIVE → outputs at reset values immediately; after release no response for the aborted op; next command completes normally.
- op_count reaches 255, one more op → op_count=0.
- With ALU_DRIVER_CHECK_EN, force alu_res=0 on add a=1,b=1 → mismatch=1, err_count=1, rsp_data res=0 still returned.

Source files
------------

// File: rtl/alu_driver_if.sv
// ---------------------------------------------------------------------------
// alu_driver_if
// Command and response streams of the ALU driver.
//   cmd_valid / cmd_ready / cmd_data[10:0] : {ctrl[2:0], a[3:0], b[3:0]}
//   rsp_valid / rsp_ready / rsp_data[5:0]  : {of, car, res[3:0]}
// modport master : command source / response sink (front end, testbench)
// modport slave  : the driver itself
// ---------------------------------------------------------------------------
interface alu_driver_if;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [10:0] cmd_data;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [5:0]  rsp_data;

   modport master (
      output cmd_valid, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/alu_driver.sv
// ---------------------------------------------------------------------------
// alu_driver
// Sequential initiator for the 4-bit combinational ALU. Accepts a command,
// drives the ALU operands/opcode, waits SETTLE_CYCLES, captures
// {of, car, res} into a show-ahead response FIFO and counts completed ops.
//
// Parameters
//   SETTLE_CYCLES : cycles operands are held before capture (1..15)
//   FIFO_DEPTH    : response FIFO entries (power of two, 2..16)
// Ports
//   clk, rst_n            : clock, asynchronous active-low reset
//   bus (slave)           : command / response streams
//   alu_a, alu_b, alu_ctrl: registered ALU inputs
//   alu_res, alu_car, alu_of : ALU outputs
//   op_count              : completed operations, wraps
// Optional build macro ALU_DRIVER_CHECK_EN adds a golden-model checker:
//   mismatch  : sticky, set when a captured result differs from the model
//   err_count : saturating count of mismatching captures
// Opcodes: 0 add, 1 sub, 2 not, 3 and, 4 or, 5 xor, 6 compare, 7 equal
// ---------------------------------------------------------------------------
// state | meaning
// IDLE  | waiting for a command; ready while the FIFO has room
// DRIVE | operands held on the ALU, settle counter running down to capture
// ---------------------------------------------------------------------------
module alu_driver #(
   parameter int SETTLE_CYCLES = 1,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   alu_driver_if.slave bus,
   output logic [3:0]  alu_a,
   output logic [3:0]  alu_b,
   output logic [2:0]  alu_ctrl,
   input  logic [3:0]  alu_res,
   input  logic        alu_car,
   input  logic        alu_of,
   output logic [7:0]  op_count
`ifdef ALU_DRIVER_CHECK_EN
   ,
   output logic        mismatch,
   output logic [7:0]  err_count
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic {
      IDLE  = 1'b0,
      DRIVE = 1'b1
   } state_t;

   state_t          state_q;
   state_t          state_d;
   logic [3:0]      settle_cnt;
   logic            accept;
   logic            capture;
   logic            cmd_ready_c;

   logic [5:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]   wr_ptr;
   logic [AW-1:0]   rd_ptr;
   logic [AW-1:0]   rd_ptr_inc;
   logic [CW-1:0]   fifo_count;
   logic            rsp_valid_q;
   logic [5:0]      rsp_data_q;
   logic            pop;
   logic [5:0]      push_data;

   // ---------------- FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Nothing is in flight while IDLE, so "fifo_count + pending" reduces to
   // the FIFO occupancy; in DRIVE ready is forced low.
   always_comb begin
      state_d     = state_q;
      cmd_ready_c = 1'b0;
      accept      = 1'b0;
      capture     = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready_c = (fifo_count < CW'(FIFO_DEPTH));
            accept      = cmd_ready_c && bus.cmd_valid;
            if (accept) begin
               state_d = DRIVE;
            end
         end
         DRIVE: begin
            if (settle_cnt == 4'd1) begin
               capture = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.cmd_ready = cmd_ready_c;

   // ---------------- settle timer and operand registers ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle_cnt <= 4'd0;
         alu_a      <= 4'd0;
         alu_b      <= 4'd0;
         alu_ctrl   <= 3'b000;
      end else if (accept) begin
         settle_cnt <= 4'(SETTLE_CYCLES);
         alu_ctrl   <= bus.cmd_data[10:8];
         alu_a      <= bus.cmd_data[7:4];
         alu_b      <= bus.cmd_data[3:0];
      end else if ((state_q == DRIVE) && !capture) begin
         settle_cnt <= settle_cnt - 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_count <= 8'd0;
      end else if (capture) begin
         op_count <= op_count + 8'd1;
      end
   end

   // ---------------- response FIFO ----------------
   // Storage is written unconditionally on push; only pointers and the
   // registered head copy need reset.
   assign push_data  = {alu_of, alu_car, alu_res};
   assign pop        = rsp_valid_q && bus.rsp_ready;
   assign rd_ptr_inc = rd_ptr + AW'(1);

   always_ff @(posedge clk) begin
      if (capture) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (capture) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr_inc;
         end
         fifo_count <= fifo_count + CW'(capture) - CW'(pop);
      end
   end

   // The head is kept in its own register so rsp_data is a flop output and
   // simply holds when the FIFO drains. A push into an empty FIFO (or into a
   // FIFO whose only entry is leaving this cycle) becomes the head directly.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_data_q  <= 6'd0;
         rsp_valid_q <= 1'b0;
      end else begin
         rsp_valid_q <= ((fifo_count + CW'(capture) - CW'(pop)) != '0);
         if (pop) begin
            if (fifo_count > CW'(1)) begin
               rsp_data_q <= mem[rd_ptr_inc];
            end else if (capture) begin
               rsp_data_q <= push_data;
            end
         end else if (capture && (fifo_count == '0)) begin
            rsp_data_q <= push_data;
         end
      end
   end

   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;

`ifdef ALU_DRIVER_CHECK_EN
   // ---------------- golden-model checker ----------------
   logic [4:0] gold_sum;
   logic [3:0] gold_neg_b;
   logic [3:0] gold_res;
   logic       gold_car;
   logic       gold_of;

   // Overflow for sub uses the sign of b itself (not of the negated b),
   // matching the ALU being driven.
   always_comb begin
      gold_sum   = 5'd0;
      gold_neg_b = ~alu_b + 4'd1;
      gold_res   = 4'd0;
      gold_car   = 1'b0;
      gold_of    = 1'b0;
      case (alu_ctrl)
         3'd0: begin
            gold_sum = {1'b0, alu_a} + {1'b0, alu_b};
            gold_res = gold_sum[3:0];
            gold_car = gold_sum[4];
            gold_of  = (alu_a[3] == alu_b[3]) && (gold_sum[3] != alu_a[3]);
         end
         3'd1: begin
            gold_sum = {1'b0, alu_a} + {1'b0, gold_neg_b};
            gold_res = gold_sum[3:0];
            gold_car = gold_sum[4];
            gold_of  = (alu_a[3] == alu_b[3]) && (gold_sum[3] != alu_a[3]);
         end
         3'd2: gold_res = ~alu_a;
         3'd3: gold_res = alu_a & alu_b;
         3'd4: gold_res = alu_a | alu_b;
         3'd5: gold_res = alu_a ^ alu_b;
         3'd6: begin
            if (!alu_a[3] && alu_b[3]) begin
               gold_res = 4'd0;
            end else if (alu_a[3] && !alu_b[3]) begin
               gold_res = 4'd1;
            end else begin
               gold_res = (alu_a < alu_b) ? 4'd0 : 4'd1;
            end
         end
         3'd7: gold_res = (alu_a == alu_b) ? 4'd0 : 4'd1;
         default: gold_res = 4'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mismatch  <= 1'b0;
         err_count <= 8'd0;
      end else if (capture && (push_data != {gold_of, gold_car, gold_res})) begin
         mismatch <= 1'b1;
         if (err_count != 8'hFF) begin
            err_count <= err_count + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_alu_driver.sv
// ---------------------------------------------------------------------------
// tb_alu_driver
// Directed bench for alu_driver (SETTLE_CYCLES=1, FIFO_DEPTH=4) with a
// behavioural 4-bit ALU attached. Expected responses are hand-computed
// constants; op_count is tracked by a local counter.
// ---------------------------------------------------------------------------
module tb_alu_driver;

   logic       clk;
   logic       rst_n;
   logic [3:0] alu_a;
   logic [3:0] alu_b;
   logic [2:0] alu_ctrl;
   logic [3:0] alu_res;
   logic       alu_car;
   logic       alu_of;
   logic [7:0] op_count;
`ifdef ALU_DRIVER_CHECK_EN
   logic       mismatch;
   logic [7:0] err_count;
`endif

   logic       force_zero;
   logic [4:0] m_sum;
   logic [3:0] m_t;
   int         checks;
   int         errors;
   logic [7:0] exp_ops;

   alu_driver_if bus ();

   alu_driver #(
      .SETTLE_CYCLES (1),
      .FIFO_DEPTH    (4)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_ctrl (alu_ctrl),
      .alu_res  (alu_res),
      .alu_car  (alu_car),
      .alu_of   (alu_of),
      .op_count (op_count)
`ifdef ALU_DRIVER_CHECK_EN
      ,
      .mismatch  (mismatch),
      .err_count (err_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural ALU; force_zero corrupts the result to provoke the checker.
   always_comb begin
      m_sum   = 5'd0;
      m_t     = ~alu_b + 4'd1;
      alu_res = 4'd0;
      alu_car = 1'b0;
      alu_of  = 1'b0;
      case (alu_ctrl)
         3'd0, 3'd1: begin
            m_sum   = {1'b0, alu_a} + {1'b0, (alu_ctrl == 3'd0) ? alu_b : m_t};
            alu_res = m_sum[3:0];
            alu_car = m_sum[4];
            alu_of  = (alu_a[3] == alu_b[3]) && (m_sum[3] != alu_a[3]);
         end
         3'd2: alu_res = ~alu_a;
         3'd3: alu_res = alu_a & alu_b;
         3'd4: alu_res = alu_a | alu_b;
         3'd5: alu_res = alu_a ^ alu_b;
         3'd6: begin
            if (!alu_a[3] && alu_b[3])      alu_res = 4'd0;
            else if (alu_a[3] && !alu_b[3]) alu_res = 4'd1;
            else                            alu_res = (alu_a < alu_b) ? 4'd0 : 4'd1;
         end
         default: alu_res = (alu_a == alu_b) ? 4'd0 : 4'd1;
      endcase
      if (force_zero) alu_res = 4'd0;
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      int n;
      n = 0;
      bus.cmd_data  = {op, a, b};
      bus.cmd_valid = 1'b1;
      while (!bus.cmd_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.cmd_ready) chk("send_timeout", {15'd0, bus.cmd_ready}, 16'd1);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic take_rsp(input string tag, input logic [5:0] exp);
      int n;
      n = 0;
      while (!bus.rsp_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.rsp_valid) chk({tag, "_timeout"}, {15'd0, bus.rsp_valid}, 16'd1);
      chk(tag, {10'd0, bus.rsp_data}, {10'd0, exp});
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
   endtask

   task automatic do_op(input string tag, input logic [2:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [5:0] exp);
      send(op, a, b);
      take_rsp(tag, exp);
      exp_ops = exp_ops + 8'd1;
      chk({tag, "_cnt"}, {8'd0, op_count}, {8'd0, exp_ops});
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      checks        = 0;
      errors        = 0;
      exp_ops       = 8'd0;
      force_zero    = 1'b0;
      rst_n         = 1'b0;
      bus.cmd_valid = 1'b0;
      bus.cmd_data  = 11'd0;
      bus.rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {15'd0, bus.cmd_ready}, 16'd1);
      chk("rst_rvalid", {15'd0, bus.rsp_valid}, 16'd0);
      chk("rst_opcnt", {8'd0, op_count}, 16'd0);
      chk("rst_ab", {8'd0, alu_a, alu_b}, 16'd0);
      chk("rst_ctrl", {13'd0, alu_ctrl}, 16'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // add 7+1 with explicit latency: nothing after accept edge, data after next
      send(3'd0, 4'd7, 4'd1);
      chk("add_ab", {8'd0, alu_a, alu_b}, 16'h0071);
      chk("drive_ready", {15'd0, bus.cmd_ready}, 16'd0);
      chk("add_early", {15'd0, bus.rsp_valid}, 16'd0);
      @(posedge clk); #1;
      chk("add_valid", {15'd0, bus.rsp_valid}, 16'd1);
      chk("add_data", {10'd0, bus.rsp_data}, 16'h0028);
      chk("add_cnt", {8'd0, op_count}, 16'd1);
      chk("idle_ready", {15'd0, bus.cmd_ready}, 16'd1);
      exp_ops = 8'd1;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      chk("pop_empty", {15'd0, bus.rsp_valid}, 16'd0);
      chk("hold_data", {10'd0, bus.rsp_data}, 16'h0028);

      do_op("sub53",  3'd1, 4'd5, 4'd3, 6'h12);
      do_op("cmp29",  3'd6, 4'd2, 4'd9, 6'h00);
      do_op("eq66",   3'd7, 4'd6, 4'd6, 6'h00);
      do_op("add88",  3'd0, 4'd8, 4'd8, 6'h30);
      do_op("sub81",  3'd1, 4'd8, 4'd1, 6'h17);
      do_op("cmp92",  3'd6, 4'd9, 4'd2, 6'h01);
      do_op("cmp35",  3'd6, 4'd3, 4'd5, 6'h00);
      do_op("cmp53",  3'd6, 4'd5, 4'd3, 6'h01);
      do_op("eq67",   3'd7, 4'd6, 4'd7, 6'h01);
      chk("ctrl_hold", {13'd0, alu_ctrl}, 16'd7);

      // fill the FIFO with no consumer; fifth command must wait
      send(3'd3, 4'd12, 4'd10);
      send(3'd4, 4'd12, 4'd3);
      send(3'd5, 4'd15, 4'd5);
      send(3'd2, 4'd5, 4'd0);
      bus.cmd_data  = {3'd0, 4'd3, 4'd4};
      bus.cmd_valid = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("full_ready", {15'd0, bus.cmd_ready}, 16'd0);
      chk("full_hold_a", {12'd0, alu_a}, 16'd5);
      chk("full_head", {10'd0, bus.rsp_data}, 16'h0008);
      chk("full_cnt", {8'd0, op_count}, {8'd0, exp_ops + 8'd4});
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      chk("after_pop_ready", {15'd0, bus.cmd_ready}, 16'd1);
      send(3'd0, 4'd3, 4'd4);
      take_rsp("q_or", 6'h0F);
      take_rsp("q_xor", 6'h0A);
      take_rsp("q_not", 6'h0A);
      take_rsp("q_add", 6'h07);
      exp_ops = exp_ops + 8'd5;
      chk("q_cnt", {8'd0, op_count}, {8'd0, exp_ops});
      chk("q_empty", {15'd0, bus.rsp_valid}, 16'd0);

      // reset in the middle of DRIVE
      send(3'd1, 4'd3, 4'd4);
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_ab", {8'd0, alu_a, alu_b}, 16'd0);
      chk("mrst_ctrl", {13'd0, alu_ctrl}, 16'd0);
      chk("mrst_cnt", {8'd0, op_count}, 16'd0);
      chk("mrst_rvalid", {15'd0, bus.rsp_valid}, 16'd0);
      chk("mrst_ready", {15'd0, bus.cmd_ready}, 16'd1);
      #3 rst_n = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk("aborted_rvalid", {15'd0, bus.rsp_valid}, 16'd0);
      chk("aborted_cnt", {8'd0, op_count}, 16'd0);
      exp_ops = 8'd0;
      do_op("post_rst", 3'd3, 4'd6, 4'd3, 6'h02);

      // op_count wrap
      while (exp_ops != 8'd255) begin
         do_op("fill", 3'd5, 4'd1, 4'd1, 6'h00);
      end
      chk("cnt_255", {8'd0, op_count}, 16'd255);
      do_op("wrap", 3'd4, 4'd2, 4'd1, 6'h03);
      chk("cnt_wrap", {8'd0, op_count}, 16'd0);

`ifdef ALU_DRIVER_CHECK_EN
      chk("chk_clean", {15'd0, mismatch}, 16'd0);
      chk("chk_err0", {8'd0, err_count}, 16'd0);
      force_zero = 1'b1;
      do_op("forced", 3'd0, 4'd1, 4'd1, 6'h00);
      force_zero = 1'b0;
      chk("chk_mis", {15'd0, mismatch}, 16'd1);
      chk("chk_err1", {8'd0, err_count}, 16'd1);
      do_op("good_after", 3'd0, 4'd1, 4'd1, 6'h02);
      chk("chk_sticky", {15'd0, mismatch}, 16'd1);
      chk("chk_err_hold", {8'd0, err_count}, 16'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
